// File: rtl/parity_stream_checker.sv
// parity_stream_checker
// Streaming parity checker/generator. Each accepted word is forwarded one
// cycle later together with a regenerated parity bit, a per-word error flag
// and, on the last beat of a frame, a frame-level error flag. A saturating
// error counter and a sticky error flag provide status readout.
module parity_stream_checker #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_gen_par,
    output logic             out_par_err,
    output logic             out_last,
    output logic             out_frame_err,
    input  logic             clr,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    localparam logic             ODD_BIT = (ODD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             accept;
    logic             wordPar;
    logic             genBit;
    logic             errBit;

    logic             validQ,    validD;
    logic [WIDTH-1:0] dataQ,     dataD;
    logic             genParQ,   genParD;
    logic             parErrQ,   parErrD;
    logic             lastQ,     lastD;
    logic             frameErrQ, frameErrD;
    logic             frmAccQ,   frmAccD;
    logic [CNT_W-1:0] errCountQ, errCountD;
    logic             stickyQ,   stickyD;

    // The output slot is free when empty or when it drains this cycle,
    // which lets a new word follow back-to-back at one beat per cycle.
    assign in_ready = !validQ || out_ready;
    assign accept   = in_valid && in_ready;

    assign wordPar = ^in_data;
    assign genBit  = wordPar ^ ODD_BIT;
    assign errBit  = wordPar ^ in_par ^ ODD_BIT;

    assign out_valid     = validQ;
    assign out_data      = dataQ;
    assign out_gen_par   = genParQ;
    assign out_par_err   = parErrQ;
    assign out_last      = lastQ;
    assign out_frame_err = frameErrQ;
    assign err_count     = errCountQ;
    assign err_sticky    = stickyQ;

    // Next state of the output beat and the frame accumulator: capture on
    // accept, hold under backpressure, drop valid after a plain transfer.
    always_comb begin
        validD    = validQ;
        dataD     = dataQ;
        genParD   = genParQ;
        parErrD   = parErrQ;
        lastD     = lastQ;
        frameErrD = frameErrQ;
        frmAccD   = frmAccQ;
        if (accept) begin
            validD  = 1'b1;
            dataD   = in_data;
            genParD = genBit;
            parErrD = errBit;
            lastD   = in_last;
            if (in_last) begin
                frameErrD = frmAccQ | errBit;
                frmAccD   = 1'b0;
            end else begin
                frameErrD = 1'b0;
                frmAccD   = frmAccQ | errBit;
            end
        end else if (out_ready) begin
            validD = 1'b0;
        end
    end

    // Next state of the status counters: clr wins over a simultaneous
    // error, and errors are counted once at input accept.
    always_comb begin
        errCountD = errCountQ;
        stickyD   = stickyQ;
        if (clr) begin
            errCountD = '0;
            stickyD   = 1'b0;
        end else if (accept && errBit) begin
            stickyD = 1'b1;
            if (errCountQ != CNT_MAX) begin
                errCountD = errCountQ + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset; reset also discards any held
    // output beat and a partially accumulated frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ    <= 1'b0;
            dataQ     <= '0;
            genParQ   <= 1'b0;
            parErrQ   <= 1'b0;
            lastQ     <= 1'b0;
            frameErrQ <= 1'b0;
            frmAccQ   <= 1'b0;
            errCountQ <= '0;
            stickyQ   <= 1'b0;
        end else begin
            validQ    <= validD;
            dataQ     <= dataD;
            genParQ   <= genParD;
            parErrQ   <= parErrD;
            lastQ     <= lastD;
            frameErrQ <= frameErrD;
            frmAccQ   <= frmAccD;
            errCountQ <= errCountD;
            stickyQ   <= stickyD;
        end
    end

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker
// Directed bench for parity_stream_checker: even-parity 8-bit instance with
// an 8-bit counter, an odd-parity instance, and an even-parity instance with
// a 2-bit counter for saturation, clr priority and mid-frame reset.
module tb_parity_stream_checker;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    // Even parity, 8-bit counter
    logic       inValid0, inReady0, inPar0, inLast0;
    logic [7:0] inData0;
    logic       outValid0, outReady0, outGen0, outErr0, outLast0, outFrame0;
    logic [7:0] outData0;
    logic [7:0] errCount0;
    logic       sticky0;

    // Odd parity
    logic       inValid1, inReady1, inPar1, inLast1;
    logic [7:0] inData1;
    logic       outValid1, outReady1, outGen1, outErr1, outLast1, outFrame1;
    logic [7:0] outData1;
    logic [7:0] errCount1;
    logic       sticky1;

    // Even parity, 2-bit counter
    logic       inValid2, inReady2, inPar2, inLast2;
    logic [7:0] inData2;
    logic       outValid2, outReady2, outGen2, outErr2, outLast2, outFrame2;
    logic [7:0] outData2;
    logic [1:0] errCount2;
    logic       sticky2;

    int checks = 0;
    int errors = 0;

    parity_stream_checker #(.WIDTH(8), .ODD(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0),
        .in_par(inPar0), .in_last(inLast0),
        .out_valid(outValid0), .out_ready(outReady0), .out_data(outData0),
        .out_gen_par(outGen0), .out_par_err(outErr0), .out_last(outLast0),
        .out_frame_err(outFrame0),
        .clr(clr), .err_count(errCount0), .err_sticky(sticky0)
    );

    parity_stream_checker #(.WIDTH(8), .ODD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
        .in_par(inPar1), .in_last(inLast1),
        .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1),
        .out_gen_par(outGen1), .out_par_err(outErr1), .out_last(outLast1),
        .out_frame_err(outFrame1),
        .clr(clr), .err_count(errCount1), .err_sticky(sticky1)
    );

    parity_stream_checker #(.WIDTH(8), .ODD(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .in_par(inPar2), .in_last(inLast2),
        .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2),
        .out_gen_par(outGen2), .out_par_err(outErr2), .out_last(outLast2),
        .out_frame_err(outFrame2),
        .clr(clr), .err_count(errCount2), .err_sticky(sticky2)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       last;
        logic       expGen;
        logic       expErr;
        logic       expFrame;
        logic [7:0] expCount;
        logic       expSticky;
    } vec_t;

    vec_t vecs [8];

    // Advance to just after the next rising edge so registered outputs are settled.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Present one beat to the even-parity 8-bit-counter instance.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic last);
        inValid0 = 1'b1;
        inData0  = data;
        inPar0   = par;
        inLast0  = last;
    endtask

    initial begin
        int expSat [5];

        // field order: data, par, last, expGen, expErr, expFrame, expCount, expSticky
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1};
        vecs[2] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        vecs[3] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[4] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[7] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1};
        expSat[0] = 1; expSat[1] = 2; expSat[2] = 3; expSat[3] = 3; expSat[4] = 3;

        rst = 1'b1; clr = 1'b0;
        inValid0 = 1'b0; inData0 = 8'h00; inPar0 = 1'b0; inLast0 = 1'b0; outReady0 = 1'b1;
        inValid1 = 1'b0; inData1 = 8'h00; inPar1 = 1'b0; inLast1 = 1'b0; outReady1 = 1'b1;
        inValid2 = 1'b0; inData2 = 8'h00; inPar2 = 1'b0; inLast2 = 1'b0; outReady2 = 1'b1;
        waitCycle();
        waitCycle();
        checkOutput("reset out_valid", outValid0, 0);
        checkOutput("reset out_data", outData0, 0);
        checkOutput("reset out_gen_par", outGen0, 0);
        checkOutput("reset out_par_err", outErr0, 0);
        checkOutput("reset out_last", outLast0, 0);
        checkOutput("reset out_frame_err", outFrame0, 0);
        checkOutput("reset err_count", errCount0, 0);
        checkOutput("reset err_sticky", sticky0, 0);
        rst = 1'b0;

        // Table-driven stream at full throughput, even parity
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].data, vecs[i].par, vecs[i].last);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), inReady0, 1);
            waitCycle();
            checkOutput($sformatf("vec%0d out_valid", i), outValid0, 1);
            checkOutput($sformatf("vec%0d out_data", i), outData0, vecs[i].data);
            checkOutput($sformatf("vec%0d out_gen_par", i), outGen0, vecs[i].expGen);
            checkOutput($sformatf("vec%0d out_par_err", i), outErr0, vecs[i].expErr);
            checkOutput($sformatf("vec%0d out_last", i), outLast0, vecs[i].last);
            checkOutput($sformatf("vec%0d out_frame_err", i), outFrame0, vecs[i].expFrame);
            checkOutput($sformatf("vec%0d err_count", i), errCount0, vecs[i].expCount);
            checkOutput($sformatf("vec%0d err_sticky", i), sticky0, vecs[i].expSticky);
        end
        inValid0 = 1'b0;
        waitCycle();
        checkOutput("drain out_valid", outValid0, 0);

        // Backpressure: errored word 8'h03 with in_par=1 held for 4 cycles
        outReady0 = 1'b0;
        applyStimulus(8'h03, 1'b1, 1'b1);
        #1;
        checkOutput("bp first in_ready", inReady0, 1);
        waitCycle();
        checkOutput("bp out_valid", outValid0, 1);
        checkOutput("bp out_par_err", outErr0, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp%0d in_ready", i), inReady0, 0);
            checkOutput($sformatf("bp%0d out_data", i), outData0, 8'h03);
            checkOutput($sformatf("bp%0d err_count", i), errCount0, 3);
            if (i < 3) waitCycle();
        end
        outReady0 = 1'b1;
        applyStimulus(8'h11, 1'b0, 1'b0);
        #1;
        checkOutput("release in_ready 0", inReady0, 1);
        waitCycle();
        checkOutput("release out_data 0", outData0, 8'h11);
        applyStimulus(8'h22, 1'b0, 1'b0);
        #1;
        checkOutput("release in_ready 1", inReady0, 1);
        waitCycle();
        checkOutput("release out_data 1", outData0, 8'h22);
        applyStimulus(8'h33, 1'b0, 1'b1);
        #1;
        checkOutput("release in_ready 2", inReady0, 1);
        waitCycle();
        checkOutput("release out_data 2", outData0, 8'h33);
        checkOutput("release out_frame_err", outFrame0, 0);
        checkOutput("release err_count", errCount0, 3);
        inValid0 = 1'b0;

        // Odd parity instance
        inValid1 = 1'b1; inData1 = 8'h00; inPar1 = 1'b1; inLast1 = 1'b1;
        waitCycle();
        checkOutput("odd clean out_par_err", outErr1, 0);
        checkOutput("odd clean out_gen_par", outGen1, 1);
        checkOutput("odd clean out_frame_err", outFrame1, 0);
        inPar1 = 1'b0;
        waitCycle();
        checkOutput("odd bad out_par_err", outErr1, 1);
        checkOutput("odd bad out_gen_par", outGen1, 1);
        checkOutput("odd bad err_count", errCount1, 1);
        inValid1 = 1'b0;

        // Saturation with a 2-bit counter
        inValid2 = 1'b1; inData2 = 8'h01; inPar2 = 1'b0; inLast2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkOutput($sformatf("sat%0d err_count", i), errCount2, expSat[i]);
            checkOutput($sformatf("sat%0d err_sticky", i), sticky2, 1);
        end

        // clr together with an errored accept: clr wins, datapath unaffected
        clr = 1'b1;
        waitCycle();
        clr = 1'b0;
        checkOutput("clr err_count", errCount2, 0);
        checkOutput("clr err_sticky", sticky2, 0);
        checkOutput("clr out_par_err", outErr2, 1);

        // Errored non-last beat, then reset mid-frame
        inLast2 = 1'b0;
        waitCycle();
        checkOutput("midframe err_count", errCount2, 1);
        inValid2 = 1'b0;
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        checkOutput("rst out_valid", outValid2, 0);
        checkOutput("rst out_data", outData2, 0);
        checkOutput("rst out_par_err", outErr2, 0);
        checkOutput("rst out_frame_err", outFrame2, 0);
        checkOutput("rst out_last", outLast2, 0);
        checkOutput("rst err_count", errCount2, 0);
        checkOutput("rst err_sticky", sticky2, 0);
        inValid2 = 1'b1; inData2 = 8'h00; inPar2 = 1'b0; inLast2 = 1'b1;
        waitCycle();
        inValid2 = 1'b0;
        checkOutput("post-rst out_valid", outValid2, 1);
        checkOutput("post-rst out_last", outLast2, 1);
        checkOutput("post-rst out_par_err", outErr2, 0);
        checkOutput("post-rst out_frame_err", outFrame2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
